// File: rtl/mul_pkg.sv
// Shared types and widths for the nibble-sequenced 8x8 multiplier.
package mul_pkg;

  localparam int unsigned STEP_W    = 2;
  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned PROD_W    = 16;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } mul_state_t;

endpackage

// File: rtl/BinaryMul4bit.sv
// Combinational 4x4 unsigned multiplier shared by the sequential controller.
module BinaryMul4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] M
);

  assign M = {4'b0000, A} * {4'b0000, B};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiplier built from four passes through one 4x4 multiplier,
// shift-accumulating the nibble products into a 16-bit result.
module mul8_seq_ctrl
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     A,
  input  logic [OP_W-1:0]     B,
  output logic                busy,
  output logic                done,
  output logic [PROD_W-1:0]   P
);

  mul_state_t              state;
  logic [STEP_W-1:0]       step;
  logic [OP_W-1:0]         a_q;
  logic [OP_W-1:0]         b_q;
  logic [PROD_W-1:0]       acc;

  logic                    a_hi;
  logic                    b_hi;
  logic [3:0]              shamt;
  logic [NIB_W-1:0]        nib_a;
  logic [NIB_W-1:0]        nib_b;
  logic [2*NIB_W-1:0]      m;
  logic [PROD_W-1:0]       term;
  logic [PROD_W-1:0]       sum;

  // Step decode: which nibbles feed the 4x4 array and how far the product shifts.
  always_comb begin
    a_hi  = 1'b0;
    b_hi  = 1'b0;
    shamt = 4'd0;
    unique case (step)
      2'd0: begin
        a_hi  = 1'b0;
        b_hi  = 1'b0;
        shamt = 4'd0;
      end
      2'd1: begin
        a_hi  = 1'b1;
        shamt = 4'd4;
      end
      2'd2: begin
        b_hi  = 1'b1;
        shamt = 4'd4;
      end
      2'd3: begin
        a_hi  = 1'b1;
        b_hi  = 1'b1;
        shamt = 4'd8;
      end
    endcase
  end

  assign nib_a = a_hi ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
  assign nib_b = b_hi ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

  BinaryMul4bit u_mul4 (
    .A (nib_a),
    .B (nib_b),
    .M (m)
  );

  assign term = {{(PROD_W - 2*NIB_W){1'b0}}, m} << shamt;
  // Step 0 overwrites the accumulator, so no clear cycle is needed between ops.
  assign sum  = (step == '0) ? term : acc + term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            step  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= sum;
          step <= step + 1'b1;
          if (step == STEP_W'(NUM_STEPS - 1)) begin
            P     <= sum;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: vector table, scoreboard on done, corner sequences.
module tb_mul8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] P;

  mul8_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected product.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        n_done++;
        if (prev_done) check("done_width", 32'(prev_done), 32'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          check("product", 32'(P), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_done = done;
  end

  // Drive a request at the current negedge; returns at the negedge after the accept edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(p);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, scrambling A/B meanwhile; checks edges-to-done.
  task automatic wait_done(input int exp_lat, input string tag);
    int   lat;
    logic busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      A = 8'($urandom);
      B = 8'($urandom);
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'(1));
    check({tag, "_busy_clear"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic [15:0] p_hold;
    int          d0;
    logic [7:0]  ra;
    logic [7:0]  rb;

    vecs[0] = '{8'h00, 8'h00, 16'h0000};
    vecs[1] = '{8'h01, 8'hAB, 16'h00AB};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{8'h12, 8'h34, 16'h03A8};
    vecs[4] = '{8'hC8, 8'h75, 16'h5B68};
    vecs[5] = '{8'h80, 8'h02, 16'h0100};
    vecs[6] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[7] = '{8'hAA, 8'h55, 16'h3872};

    rst = 1'b1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_P", 32'(P), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].p);
      check("busy_on", 32'(busy), 32'(1));
      wait_done(4, "vec");
      p_hold = P;
      @(negedge clk);
      check("done_drop", 32'(done), 32'(0));
      check("P_hold", 32'(P), 32'(p_hold));
      check("P_hold_val", 32'(P), 32'(vecs[i].p));
    end

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      launch(ra, rb, 16'(ra) * 16'(rb));
      wait_done(4, "rand");
      @(negedge clk);
    end

    // Start while busy: second request must be dropped.
    d0 = n_done;
    launch(8'h12, 8'h34, 16'h03A8);
    @(negedge clk);
    A = 8'hFF;
    B = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, "busy_start");
    repeat (8) @(negedge clk);
    check("busy_start_dones", 32'(n_done - d0), 32'(1));
    check("busy_start_idle", 32'(busy), 32'(0));

    // Back-to-back: new start in the done cycle.
    launch(8'h33, 8'h07, 16'h0165);
    wait_done(4, "b2b_first");
    launch(8'h0F, 8'h10, 16'h00F0);
    check("b2b_accept", 32'(busy), 32'(1));
    wait_done(4, "b2b_second");
    @(negedge clk);

    // Reset mid-operation: abort, outputs return to reset values, no done follows.
    launch(8'hFF, 8'hFF, 16'hFE01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_P", 32'(P), 32'(0));
    d0 = n_done;
    repeat (8) @(negedge clk);
    check("midrst_no_done", 32'(n_done - d0), 32'(0));
    launch(8'hC8, 8'h75, 16'h5B68);
    wait_done(4, "after_rst");
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul8_seq_ctrl.md
# mul8_seq_ctrl

Sequential 8x8 unsigned multiplier controller that time-shares one combinational 4x4 multiplier (`BinaryMul4bit`) across four nibble steps. It latches operands on a start pulse, issues the four nibble-pair products, shift-accumulates them into a 16-bit result, and signals completion with a one-cycle `done` pulse. It sits between a requesting master and the 4x4 multiplier datapath, so wider products need no wider array.

## Interface
- No parameters. Widths are fixed at 8x8→16 by the 4x4→8 datapath.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only while `busy`=0.
- `A` in 8: multiplicand, unsigned; sampled with `start`.
- `B` in 8: multiplier, unsigned; sampled with `start`.
- `busy` out 1: high while a multiplication is in progress.
- `done` out 1: one-cycle pulse; `P` is valid and new.
- `P` out 16: product A*B; holds its value until the next completion.

## Operation
- FSM states:
  - IDLE → RUN on `start`=1.
  - RUN → IDLE after step 3.
  - 2-bit step counter `step`, cleared on entry to RUN.
- On accept: latch A→`a_q` and B→`b_q`. Later changes on A and B have no effect on the operation in flight.
- Step order (nibble index of a, nibble index of b, shift):
  - step 0: (0,0), shift 0
  - step 1: (1,0), shift 4
  - step 2: (0,1), shift 4
  - step 3: (1,1), shift 8
- Datapath inputs are nibbles muxed from `a_q`/`b_q` by `step`. M (8 bits) is zero-extended to 16 bits and shifted left by the step's shift amount.
- Accumulator `acc` (16 bits):
  - step 0 loads `acc` = the shifted product; no separate clear cycle.
  - steps 1–3 add the shifted product to `acc`.
- No overflow is possible: the max sum is 0xFE01, which fits in 16 bits. No carry-out is kept.
- At step 3: `P` ← `acc` + the step-3 term, `done` ← 1, `busy` ← 0, FSM → IDLE.
- `start` while `busy`=1 is ignored. There is no queueing and no error flag.
- `start` in the same cycle as `done`=1 is accepted, because `busy` is already 0. This gives back-to-back operation.

## Timing
- Reset values: `busy`=0, `done`=0, `P`=0x0000, state IDLE, `step`=0, `acc`=0.
- Reset mid-operation: abort immediately; all outputs take their reset values; no `done` pulse follows.
- Accept edge E0, when `start`=1 and `busy`=0. `busy`=1 from the cycle after E0.
- Steps execute at edges E1..E4, one per edge.
- At E4: `P` is updated, `done`=1 for exactly one cycle, `busy`=0.
- Latency is 4 cycles from accept to `done`. Throughput is one result per 4 cycles.
- `done` is registered and is never high for two consecutive cycles.
- `P` changes only at a completion edge or on reset.
- The 4x4 multiplier is combinational. Its path is nibble mux → multiplier → shift → 16-bit add, within one cycle.

## Structure
- Shared package `mul_pkg`:
  - state typedef `mul_state_t` {IDLE, RUN}
  - `STEP_W`=2, `NUM_STEPS`=4
  - `NIB_W`=4, `OP_W`=8, `PROD_W`=16
- Sub-module: one instance of the existing `BinaryMul4bit` (A, B, M), driven by the step-muxed nibbles. No other sub-modules.
- The step→nibble-select/shift decode is a small combinational case inside `mul8_seq_ctrl`.

## Test plan
- Zero and identity: start A=0x00, B=0x00 → after 4 cycles `done` pulse, P=0x0000. Then A=0x01, B=0xAB → P=0x00AB.
- Max operands: A=0xFF, B=0xFF → P=0xFE01, `done` on the 4th edge after accept, `busy` high for exactly 4 cycles.
- Mixed nibbles: A=0x12, B=0x34 → P=0x03A8. Then A=0xC8, B=0x75 → P=0x5B68. Change A/B during `busy` → result unaffected.
- Start while busy: start 0x12*0x34, pulse `start` with 0xFF*0xFF at the 2nd busy cycle → single `done`, P=0x03A8, second request dropped.
- Back-to-back: assert `start` (A=0x0F, B=0x10) in the `done` cycle of a prior op → accepted, next `done` 4 cycles later with P=0x00F0.
- Reset mid-op: start 0xFF*0xFF, assert `rst` at the 2nd step → next cycle `busy`=0, `done`=0, P=0x0000, no `done` afterwards. A new start then completes correctly.
